// File: rtl/dac_rx_pkg.sv
// Shared definitions for the DAC sample receive path.
//
// Contents:
//   rx_state_t  - prime/run FSM states (FILL while priming, RUN while feeding the DAC)
//   FRAME_CNT_W - width of the frame counter reported to the register block
//   level_width - number of bits needed to hold a FIFO occupancy of 0..depth
package dac_rx_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } rx_state_t;

    localparam int FRAME_CNT_W = 16;

    // Occupancy runs from 0 to depth inclusive, so one bit more than the
    // address width is required.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding accepted DAC samples.
//
// Parameters:
//   WIDTH - data width in bits
//   DEPTH - number of entries (power of 2)
//
// Ports:
//   aclk      in   system clock, rising edge
//   areset    in   synchronous active-high reset, empties the FIFO
//   wr_en     in   push wr_data (ignored when full)
//   wr_data   in   data to push
//   rd_en     in   pop the head entry (ignored when empty)
//   rd_data   out  current head entry, valid while !empty
//   full      out  occupancy equals DEPTH
//   empty     out  occupancy is zero
//   level     out  current occupancy 0..DEPTH
module sync_fifo
    import dac_rx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic                          rd_en,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];

    // Storage array. It needs no reset: emptiness is tracked by the pointers
    // and count, so stale entries are never visible after a flush.
    always_ff @(posedge aclk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping. Pointers wrap naturally because
    // DEPTH is a power of two. A simultaneous push and pop leaves the count
    // unchanged.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axis_dac_sample_rx.sv
// AXI-Stream slave that terminates the DAC sample stream.
//
// Beats carrying the configured stream ID with all bytes kept are buffered
// in a FIFO. A prime/run FSM waits for START_LEVEL samples, then releases one
// sample per DAC rate strobe. Status (underrun, bad keep, frame count) is
// reported to the register block.
//
// Ports:
//   aclk            in   system clock
//   areset          in   synchronous active-high reset
//   s_axis_tvalid   in   AXI-S valid
//   s_axis_tready   out  AXI-S ready (registered, low when FIFO full)
//   s_axis_tlast    in   end of frame
//   s_axis_tdata    in   sample
//   s_axis_tid      in   stream ID
//   s_axis_tkeep    in   byte keep, must be all-ones for a valid sample
//   s_axis_tstrb    in   byte strobe, ignored
//   cfg_tid         in   stream ID to accept
//   dac_strobe      in   one-cycle sample request
//   dac_data        out  sample to the DAC, held between updates
//   dac_data_valid  out  one-cycle pulse when dac_data updates
//   fifo_level      out  FIFO occupancy
//   running         out  FSM is in RUN
//   underrun        out  sticky: strobe in RUN with FIFO empty
//   err_keep        out  sticky: matching beat with partial keep
//   frame_cnt       out  accepted matching tlast beats, wraps
//   clr_status      in   clears underrun and err_keep
module axis_dac_sample_rx
    import dac_rx_pkg::*;
#(
    parameter int DATA_SIZE   = 32,
    parameter int ID_SIZE     = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int START_LEVEL = 4
) (
    input  logic                               aclk,
    input  logic                               areset,
    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    input  logic                               s_axis_tlast,
    input  logic [DATA_SIZE-1:0]               s_axis_tdata,
    input  logic [ID_SIZE-1:0]                 s_axis_tid,
    input  logic [DATA_SIZE/8-1:0]             s_axis_tkeep,
    input  logic [DATA_SIZE/8-1:0]             s_axis_tstrb,
    input  logic [ID_SIZE-1:0]                 cfg_tid,
    input  logic                               dac_strobe,
    output logic [DATA_SIZE-1:0]               dac_data,
    output logic                               dac_data_valid,
    output logic [level_width(FIFO_DEPTH)-1:0] fifo_level,
    output logic                               running,
    output logic                               underrun,
    output logic                               err_keep,
    output logic [FRAME_CNT_W-1:0]             frame_cnt,
    input  logic                               clr_status
);

    localparam int LW = level_width(FIFO_DEPTH);

    rx_state_t            state_q;
    rx_state_t            state_d;
    logic                 tready_q;
    logic                 accept;
    logic                 id_match;
    logic                 keep_full;
    logic                 wr_en;
    logic                 pop;
    logic                 underrun_evt;
    logic                 keep_err_evt;
    logic                 frame_evt;
    logic [LW-1:0]        level;
    logic [LW-1:0]        level_nxt;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_SIZE-1:0] fifo_rd_data;
    logic [DATA_SIZE-1:0] dac_data_q;
    logic                 dac_valid_q;
    logic                 underrun_q;
    logic                 err_keep_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic                 unused_tstrb;

    // Byte strobe carries no meaning for DAC samples.
    assign unused_tstrb = ^s_axis_tstrb;

    // Beat classification. Mismatched IDs are consumed silently; a matching
    // beat is only stored when every byte is kept.
    assign accept       = s_axis_tvalid && tready_q;
    assign id_match     = (s_axis_tid == cfg_tid);
    assign keep_full    = &s_axis_tkeep;
    assign wr_en        = accept && id_match && keep_full;
    assign keep_err_evt = accept && id_match && !keep_full;
    assign frame_evt    = accept && id_match && s_axis_tlast;

    // Strobes only act in RUN; FILL ignores them entirely.
    assign pop          = (state_q == RUN) && dac_strobe && !fifo_empty;
    assign underrun_evt = (state_q == RUN) && dac_strobe && fifo_empty;

    sync_fifo #(
        .WIDTH (DATA_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .areset  (areset),
        .wr_en   (wr_en),
        .wr_data (s_axis_tdata),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // Occupancy after this edge. tready is registered from this value so it
    // drops in the same cycle the FIFO becomes full, and no beat can ever
    // arrive at a full FIFO.
    always_comb begin
        level_nxt = level;
        case ({wr_en, pop})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    // Prime/run next-state logic: leave FILL once enough samples are
    // buffered, fall back to FILL on an underrun so the FIFO re-primes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (level >= LW'(START_LEVEL)) state_d = RUN;
            RUN:     if (underrun_evt) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Registered state, handshake, DAC output and status. Error sets take
    // priority over clr_status so an event in the clearing cycle is kept.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= FILL;
            tready_q    <= 1'b0;
            dac_data_q  <= '0;
            dac_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            err_keep_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tready_q    <= (level_nxt != LW'(FIFO_DEPTH));
            dac_valid_q <= pop;
            if (pop) begin
                dac_data_q <= fifo_rd_data;
            end
            if (underrun_evt) begin
                underrun_q <= 1'b1;
            end else if (clr_status) begin
                underrun_q <= 1'b0;
            end
            if (keep_err_evt) begin
                err_keep_q <= 1'b1;
            end else if (clr_status) begin
                err_keep_q <= 1'b0;
            end
            if (frame_evt) begin
                frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
            end
        end
    end

    assign s_axis_tready  = tready_q;
    assign dac_data       = dac_data_q;
    assign dac_data_valid = dac_valid_q;
    assign fifo_level     = level;
    assign running        = (state_q == RUN);
    assign underrun       = underrun_q;
    assign err_keep       = err_keep_q;
    assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_axis_dac_sample_rx.sv
// Directed testbench for axis_dac_sample_rx. Inputs are driven on the falling
// edge and outputs are sampled on the falling edge, away from the active edge.
module tb_axis_dac_sample_rx;

    logic        aclk;
    logic        areset;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tid;
    logic [3:0]  s_axis_tkeep;
    logic [3:0]  s_axis_tstrb;
    logic [3:0]  cfg_tid;
    logic        dac_strobe;
    logic [31:0] dac_data;
    logic        dac_data_valid;
    logic [4:0]  fifo_level;
    logic        running;
    logic        underrun;
    logic        err_keep;
    logic [15:0] frame_cnt;
    logic        clr_status;

    int n_cmp = 0;
    int n_err = 0;

    axis_dac_sample_rx #(
        .DATA_SIZE   (32),
        .ID_SIZE     (4),
        .FIFO_DEPTH  (16),
        .START_LEVEL (4)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tid     (s_axis_tid),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tstrb   (s_axis_tstrb),
        .cfg_tid        (cfg_tid),
        .dac_strobe     (dac_strobe),
        .dac_data       (dac_data),
        .dac_data_valid (dac_data_valid),
        .fifo_level     (fifo_level),
        .running        (running),
        .underrun       (underrun),
        .err_keep       (err_keep),
        .frame_cnt      (frame_cnt),
        .clr_status     (clr_status)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Offers one beat starting at a falling edge and holds it until the
    // handshake completes. tready is registered, so its value before the
    // rising edge decides acceptance at that edge.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] id,
                             input logic [3:0] keep, input logic last);
        logic acc;
        acc           = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tid    = id;
        s_axis_tkeep  = keep;
        s_axis_tlast  = last;
        for (int i = 0; i < 64 && !acc; i++) begin
            acc = s_axis_tready;
            @(negedge aclk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (!acc) begin
            n_cmp++; n_err++;
            $display("[TB] FAIL send_beat_timeout: data %h never accepted", d);
        end
    endtask

    // One-cycle strobe; returns on the falling edge where the pop result is visible.
    task automatic strobe();
        dac_strobe = 1'b1;
        @(negedge aclk);
        dac_strobe = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_tready: got %b want 0", s_axis_tready); end
        n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("[TB] FAIL reset_level: got %0d want 0", fifo_level); end
        n_cmp++; if ({running, underrun, err_keep, dac_data_valid} !== 4'b0) begin n_err++; $display("[TB] FAIL reset_flags: got %b want 0000", {running, underrun, err_keep, dac_data_valid}); end
        n_cmp++; if ({dac_data, frame_cnt} !== 48'h0) begin n_err++; $display("[TB] FAIL reset_data_cnt: got %h want 0", {dac_data, frame_cnt}); end
        areset = 1'b0;
        @(negedge aclk);
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("[TB] FAIL release_tready: got %b want 1", s_axis_tready); end
    endtask

    task automatic test_basic();
        logic [31:0] exp_d [4];
        exp_d = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) send_beat(exp_d[i], 4'd3, 4'hF, i == 3);
        @(negedge aclk);
        n_cmp++; if (running !== 1'b1) begin n_err++; $display("[TB] FAIL basic_running: got %b want 1", running); end
        n_cmp++; if (frame_cnt !== 16'd1) begin n_err++; $display("[TB] FAIL basic_frame_cnt: got %0d want 1", frame_cnt); end
        n_cmp++; if (fifo_level !== 5'd4) begin n_err++; $display("[TB] FAIL basic_level: got %0d want 4", fifo_level); end
        for (int i = 0; i < 4; i++) begin
            strobe();
            n_cmp++; if (dac_data_valid !== 1'b1) begin n_err++; $display("[TB] FAIL basic_valid_%0d: got %b want 1", i, dac_data_valid); end
            n_cmp++; if (dac_data !== exp_d[i]) begin n_err++; $display("[TB] FAIL basic_data_%0d: got %h want %h", i, dac_data, exp_d[i]); end
            @(negedge aclk);
            n_cmp++; if (dac_data_valid !== 1'b0) begin n_err++; $display("[TB] FAIL basic_pulse_%0d: got %b want 0", i, dac_data_valid); end
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) send_beat(32'h100 + i, 4'd3, 4'hF, 1'b0);
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("[TB] FAIL full_tready: got %b want 0", s_axis_tready); end
        n_cmp++; if (fifo_level !== 5'd16) begin n_err++; $display("[TB] FAIL full_level: got %0d want 16", fifo_level); end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hDEAD;
        s_axis_tid    = 4'd3;
        s_axis_tkeep  = 4'hF;
        repeat (3) @(negedge aclk);
        s_axis_tvalid = 1'b0;
        n_cmp++; if (fifo_level !== 5'd16) begin n_err++; $display("[TB] FAIL full_stall_level: got %0d want 16", fifo_level); end
        strobe();
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("[TB] FAIL full_tready_back: got %b want 1", s_axis_tready); end
        n_cmp++; if (dac_data !== 32'h100) begin n_err++; $display("[TB] FAIL full_head: got %h want 00000100", dac_data); end
        for (int i = 1; i < 15; i++) strobe();
        n_cmp++; if (dac_data !== 32'h10E) begin n_err++; $display("[TB] FAIL full_drain_data: got %h want 0000010e", dac_data); end
        n_cmp++; if (fifo_level !== 5'd1) begin n_err++; $display("[TB] FAIL full_drain_level: got %0d want 1", fifo_level); end
    endtask

    task automatic test_underrun();
        strobe();
        n_cmp++; if (dac_data !== 32'h10F || dac_data_valid !== 1'b1) begin n_err++; $display("[TB] FAIL ur_last: got %h/%b want 0000010f/1", dac_data, dac_data_valid); end
        strobe();
        n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("[TB] FAIL ur_flag: got %b want 1", underrun); end
        n_cmp++; if (dac_data_valid !== 1'b0) begin n_err++; $display("[TB] FAIL ur_valid: got %b want 0", dac_data_valid); end
        n_cmp++; if (dac_data !== 32'h10F) begin n_err++; $display("[TB] FAIL ur_hold: got %h want 0000010f", dac_data); end
        n_cmp++; if (running !== 1'b0) begin n_err++; $display("[TB] FAIL ur_fill: got %b want 0", running); end
        clr_status = 1'b1;
        @(negedge aclk);
        clr_status = 1'b0;
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("[TB] FAIL ur_clear: got %b want 0", underrun); end
        strobe();
        n_cmp++; if ({underrun, dac_data_valid} !== 2'b00) begin n_err++; $display("[TB] FAIL fill_strobe: got %b want 00", {underrun, dac_data_valid}); end
    endtask

    task automatic test_filter();
        send_beat(32'hAAAA, 4'd5, 4'hF, 1'b1);
        send_beat(32'hBBBB, 4'd5, 4'b0111, 1'b1);
        n_cmp++; if ({fifo_level, frame_cnt, err_keep} !== {5'd0, 16'd1, 1'b0}) begin n_err++; $display("[TB] FAIL filter_tid: got lvl %0d cnt %0d err %b want 0/1/0", fifo_level, frame_cnt, err_keep); end
        send_beat(32'hCCCC, 4'd3, 4'b0111, 1'b1);
        n_cmp++; if (err_keep !== 1'b1) begin n_err++; $display("[TB] FAIL keep_err: got %b want 1", err_keep); end
        n_cmp++; if (frame_cnt !== 16'd2) begin n_err++; $display("[TB] FAIL keep_frame: got %0d want 2", frame_cnt); end
        n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("[TB] FAIL keep_level: got %0d want 0", fifo_level); end
        clr_status = 1'b1;
        send_beat(32'hDDDD, 4'd3, 4'b1110, 1'b0);
        clr_status = 1'b0;
        n_cmp++; if (err_keep !== 1'b1) begin n_err++; $display("[TB] FAIL set_beats_clr: got %b want 1", err_keep); end
        clr_status = 1'b1;
        @(negedge aclk);
        clr_status = 1'b0;
        n_cmp++; if (err_keep !== 1'b0) begin n_err++; $display("[TB] FAIL keep_clear: got %b want 0", err_keep); end
    endtask

    task automatic test_reset_mid_frame();
        send_beat(32'h0, 4'd3, 4'b0011, 1'b0);
        for (int i = 0; i < 7; i++) send_beat(32'h200 + i, 4'd3, 4'hF, 1'b0);
        n_cmp++; if ({fifo_level, running, err_keep} !== {5'd7, 1'b1, 1'b1}) begin n_err++; $display("[TB] FAIL pre_reset: got lvl %0d run %b err %b want 7/1/1", fifo_level, running, err_keep); end
        areset     = 1'b1;
        dac_strobe = 1'b1;
        @(negedge aclk);
        n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("[TB] FAIL mid_reset_level: got %0d want 0", fifo_level); end
        n_cmp++; if ({running, underrun, err_keep, dac_data_valid, s_axis_tready} !== 5'b0) begin n_err++; $display("[TB] FAIL mid_reset_flags: got %b want 00000", {running, underrun, err_keep, dac_data_valid, s_axis_tready}); end
        n_cmp++; if ({dac_data, frame_cnt} !== 48'h0) begin n_err++; $display("[TB] FAIL mid_reset_regs: got %h want 0", {dac_data, frame_cnt}); end
        areset     = 1'b0;
        dac_strobe = 1'b0;
        @(negedge aclk);
        n_cmp++; if ({s_axis_tready, fifo_level} !== {1'b1, 5'd0}) begin n_err++; $display("[TB] FAIL mid_release: got rdy %b lvl %0d want 1/0", s_axis_tready, fifo_level); end
    endtask

    task automatic test_frame_wrap();
        dac_strobe = 1'b1;
        for (int k = 0; k < 65535; k++) send_beat(k, 4'd3, 4'hF, 1'b1);
        n_cmp++; if (frame_cnt !== 16'hFFFF) begin n_err++; $display("[TB] FAIL wrap_pre: got %h want ffff", frame_cnt); end
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("[TB] FAIL wrap_no_underrun: got %b want 0", underrun); end
        send_beat(32'hFFFF, 4'd3, 4'hF, 1'b1);
        n_cmp++; if (frame_cnt !== 16'h0000) begin n_err++; $display("[TB] FAIL wrap_zero: got %h want 0000", frame_cnt); end
        repeat (12) @(negedge aclk);
        dac_strobe = 1'b0;
        @(negedge aclk);
        n_cmp++; if ({fifo_level, underrun} !== {5'd0, 1'b1}) begin n_err++; $display("[TB] FAIL wrap_drain: got lvl %0d ur %b want 0/1", fifo_level, underrun); end
        n_cmp++; if (dac_data !== 32'hFFFF) begin n_err++; $display("[TB] FAIL wrap_last_data: got %h want 0000ffff", dac_data); end
    endtask

    initial begin
        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tid    = '0;
        s_axis_tkeep  = '0;
        s_axis_tstrb  = '0;
        cfg_tid       = 4'd3;
        dac_strobe    = 1'b0;
        clr_status    = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_underrun();
        test_filter();
        test_reset_mid_frame();
        test_frame_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
